// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants, direction enum and period helper for the PWM
//               duty reader and its prescaler.
// Revision    : 1.0
// ============================================================================
package pwm_pkg;

    localparam int c_default_n     = 7;
    localparam int c_default_div_w = 4;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Top count value for an n-bit counter: 2^n-2, leaving 2^n-1 as "always on".
    function automatic int unsigned pwm_max(input int unsigned n);
        return (32'd1 << n) - 32'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_prescaler
// Description : Emits one tick every (div+1) enabled clk cycles.
// Revision    : 1.0
// ============================================================================
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int DIV_W = c_default_div_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_presc;
    logic             w_wrap;

    // ">=" rather than "==" so a live decrease of div below the current count
    // wraps on the next cycle instead of running through the full range.
    assign w_wrap = (r_presc >= div);
    assign tick   = ena & w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (ena) begin
            r_presc <= w_wrap ? '0 : r_presc + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_reader.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_reader
// Description : Double-buffered PWM generator reading the duty register word.
//               Build macro PWM_PHASE_CORRECT_EN selects the centre-aligned
//               up/down counter; default is edge-aligned.
// Revision    : 1.0
// ============================================================================
module pwm_duty_reader
    import pwm_pkg::*;
#(
    parameter int N     = c_default_n,
    parameter int DIV_W = c_default_div_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] div,
    input  logic [N-1:0]     duty,
    output logic             pwm_out,
    output logic             period_start,
    output logic [N-1:0]     cnt_out
);

    localparam logic [N-1:0] c_max = N'(pwm_max(N));
    localparam logic [N-1:0] c_one = N'(1);

    logic         w_tick;
    logic         w_bottom;
    logic [N-1:0] w_cnt_next;
    logic [N-1:0] w_duty_sh_next;
    logic [N-1:0] r_cnt;
    logic [N-1:0] r_duty_sh;
    logic         r_pwm;
    logic         r_pstart;

    pwm_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .div   (div),
        .tick  (w_tick)
    );

`ifdef PWM_PHASE_CORRECT_EN
    dir_e r_dir;
    dir_e w_dir_next;

    always_comb begin
        w_dir_next = r_dir;
        w_cnt_next = r_cnt;
        w_bottom   = 1'b0;
        if (w_tick) begin
            if (r_dir == DIR_UP) begin
                if (r_cnt == c_max) begin
                    w_cnt_next = c_max - c_one;
                    w_dir_next = DIR_DOWN;
                end else begin
                    w_cnt_next = r_cnt + c_one;
                end
            end else begin
                w_cnt_next = r_cnt - c_one;
                if (r_cnt == c_one) begin
                    w_dir_next = DIR_UP;
                    w_bottom   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= DIR_UP;
        end else begin
            r_dir <= w_dir_next;
        end
    end
`else
    always_comb begin
        w_cnt_next = r_cnt;
        w_bottom   = 1'b0;
        if (w_tick) begin
            if (r_cnt == c_max) begin
                w_cnt_next = '0;
                w_bottom   = 1'b1;
            end else begin
                w_cnt_next = r_cnt + c_one;
            end
        end
    end
`endif

    // The compare uses next-state values so pwm_out lines up with cnt_out.
    assign w_duty_sh_next = w_bottom ? duty : r_duty_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_duty_sh <= '0;
            r_pwm     <= 1'b0;
            r_pstart  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_duty_sh <= w_duty_sh_next;
            r_pwm     <= (w_cnt_next < w_duty_sh_next);
            r_pstart  <= w_bottom;
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_pstart;
    assign cnt_out      = r_cnt;

endmodule
`default_nettype wire
